// File: rtl/ucode_loader.sv
// rtl/ucode_loader.sv - framed byte-stream loader writing 13-bit microinstructions into program RAM
// Optional inter-byte timeout enabled by defining UCODE_LOADER_TIMEOUT_EN.
module ucode_loader #(
  parameter int AW      = 8,
  parameter int DW      = 13,
  parameter int TIMEOUT = 50000000
) (
  input  logic          ck,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          seq_hold,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_LO, S_HI, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [AW:0] cnt;
  logic [7:0]  lo;
  logic [7:0]  sum;
  logic [7:0]  sum_nx;
  logic        take;
  logic        is_sync;
  logic        timeout_hit;

  assign take    = in_valid & in_ready;
  assign sum_nx  = sum + in_data;
  assign is_sync = (in_data == 8'hA5);

`ifdef UCODE_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          waiting;

  assign waiting = (state == S_COUNT) || (state == S_LO) ||
                   (state == S_HI) || (state == S_CSUM);

  // Held at zero outside the byte-waiting states, so entering COUNT starts from zero.
  always_ff @(posedge ck) begin
    if (rst || take || !waiting) idle_cnt <= '0;
    else                         idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit = waiting && !take && (idle_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0 & (TIMEOUT != 0);
`endif

  always_ff @(posedge ck) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b1;
    wr_en    = 1'b0;
    seq_hold = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_IDLE: begin
        if (take && is_sync) state_nx = S_COUNT;
      end
      S_COUNT: begin
        if (take)             state_nx = S_LO;
        else if (timeout_hit) state_nx = S_ERR;
      end
      S_LO: begin
        if (take)             state_nx = S_HI;
        else if (timeout_hit) state_nx = S_ERR;
      end
      S_HI: begin
        if (take)             state_nx = (in_data[7:5] != 3'b000) ? S_ERR : S_WRITE;
        else if (timeout_hit) state_nx = S_ERR;
      end
      S_WRITE: begin
        in_ready = 1'b0;
        wr_en    = 1'b1;
        state_nx = (cnt == (AW+1)'(1)) ? S_CSUM : S_LO;
      end
      S_CSUM: begin
        if (take)             state_nx = (sum_nx == 8'h00) ? S_DONE : S_ERR;
        else if (timeout_hit) state_nx = S_ERR;
      end
      S_DONE: begin
        done     = 1'b1;
        seq_hold = 1'b0;
        if (take && is_sync) state_nx = S_COUNT;
      end
      S_ERR: begin
        err = 1'b1;
        if (take && is_sync) state_nx = S_COUNT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_addr <= '0;
      wr_data <= '0;
      cnt     <= '0;
      lo      <= '0;
      sum     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (take && is_sync) begin
            sum     <= '0;
            wr_addr <= '0;
          end
        end
        S_COUNT: begin
          if (take) begin
            // N=0 encodes a full 2**AW-word image.
            cnt <= (in_data == 8'h00) ? {1'b1, {AW{1'b0}}} : (AW+1)'(in_data);
            sum <= sum_nx;
          end
        end
        S_LO: begin
          if (take) begin
            lo  <= in_data;
            sum <= sum_nx;
          end
        end
        S_HI: begin
          if (take && in_data[7:5] == 3'b000) begin
            wr_data <= {in_data[4:0], lo};
            sum     <= sum_nx;
          end
        end
        S_WRITE: begin
          wr_addr <= wr_addr + 1'b1;
          cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_loader.sv
// tb/tb_ucode_loader.sv - scoreboard bench for ucode_loader with randomized frames
module tb_ucode_loader;

  logic        ck = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [12:0] wr_data;
  logic        seq_hold;
  logic        done;
  logic        err;

  ucode_loader #(.AW(8), .DW(13), .TIMEOUT(16)) dut (
    .ck(ck), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq_hold(seq_hold), .done(done), .err(err)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  byte_q[$];
  logic [20:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Write monitor: every strobe must match the head of the expected-write queue.
  always @(negedge ck) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr", {31'd0, wr_en}, 32'd0);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, wr_addr}, {24'd0, e[20:13]});
        check("wr_data", {19'd0, wr_data}, {19'd0, e[12:0]});
        check("in_ready_during_wr", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc) begin
      acc = in_ready;
      @(negedge ck);
      if (!acc) begin
        waited++;
        if (waited > 8) begin
          check("handshake_timeout", {31'd0, in_ready}, 32'd1);
          break;
        end
      end
    end
  endtask

  task automatic send_frame(input bit gaps);
    foreach (byte_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge ck);
      end
      send_byte(byte_q[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_end(input string tag);
    check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_seq_hold"}, {31'd0, seq_hold}, {31'd0, ~exp_done});
    check({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  // Reference model: mode 0 = bad checksum, 1 = HI format error, otherwise good frame.
  task automatic build_frame(input int n, input int mode);
    logic [7:0] sum, lo, hi, ckb;
    int nw, err_at;
    byte_q.delete();
    nw = (n == 0) ? 256 : n;
    err_at = $urandom_range(0, nw - 1);
    byte_q.push_back(8'hA5);
    byte_q.push_back(n[7:0]);
    sum = n[7:0];
    for (int i = 0; i < nw; i++) begin
      lo = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 31));
      if (mode == 1 && i == err_at) hi = hi | (8'h20 << $urandom_range(0, 2));
      byte_q.push_back(lo);
      byte_q.push_back(hi);
      if (hi > 8'd31) begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
        return;
      end
      exp_q.push_back({8'(i % 256), hi[4:0], lo});
      sum = sum + lo + hi;
    end
    ckb = 8'h00 - sum;
    if (mode == 0) ckb = ckb + 8'($urandom_range(1, 255));
    byte_q.push_back(ckb);
    exp_done = (mode != 0);
    exp_err  = (mode == 0);
  endtask

  initial begin
    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge ck);
    rst = 1'b0;
    @(negedge ck);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {19'd0, wr_data}, 32'd0);
    check("rst_seq_hold", {31'd0, seq_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Known-good two-word image.
    byte_q = '{8'hA5, 8'h02, 8'h11, 8'h00, 8'h22, 8'h01, 8'hCA};
    exp_q.push_back({8'd0, 13'h0011});
    exp_q.push_back({8'd1, 13'h0122});
    exp_done = 1'b1; exp_err = 1'b0;
    send_frame(1'b0);
    check_end("t1");

    // Bad checksum after one written word.
    byte_q = '{8'hA5, 8'h01, 8'hFF, 8'h1F, 8'h00};
    exp_q.push_back({8'd0, 13'h1FFF});
    exp_done = 1'b0; exp_err = 1'b1;
    send_frame(1'b0);
    check_end("t2");

    // HI format error, then a fresh sync clears err.
    byte_q = '{8'hA5, 8'h01, 8'h00, 8'h20};
    send_frame(1'b0);
    check_end("t3");
    send_byte(8'hA5);
    in_valid = 1'b0;
    check("t3_sync_err", {31'd0, err}, 32'd0);
    check("t3_sync_hold", {31'd0, seq_hold}, 32'd1);
    byte_q = '{8'h01, 8'h00, 8'h00, 8'hFF};
    exp_q.push_back({8'd0, 13'h0000});
    exp_done = 1'b1; exp_err = 1'b0;
    send_frame(1'b0);
    check_end("t3b");

    // Full 256-word image with in_valid held high.
    build_frame(0, 2);
    send_frame(1'b0);
    check_end("t4");
    check("t4_addr_wrap", {24'd0, wr_addr}, 32'd0);

    // Reset in the middle of a frame.
    build_frame(5, 2);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({8'(i), byte_q[3 + 2*i][4:0], byte_q[2 + 2*i]});
    for (int i = 0; i < 9; i++) send_byte(byte_q[i]);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge ck);
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_wr_en", {31'd0, wr_en}, 32'd0);
    check("t5_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("t5_wr_data", {19'd0, wr_data}, 32'd0);
    check("t5_seq_hold", {31'd0, seq_hold}, 32'd1);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_err", {31'd0, err}, 32'd0);
    check("t5_writes_left", exp_q.size(), 0);
    rst = 1'b0;
    send_byte(8'h00);
    in_valid = 1'b0;
    @(negedge ck);
    check("t5_junk_wr_en", {31'd0, wr_en}, 32'd0);
    build_frame(2, 2);
    send_frame(1'b0);
    check_end("t5b");

    // Stall mid-frame for TIMEOUT cycles.
    build_frame(3, 2);
    send_byte(byte_q[0]);
    send_byte(byte_q[1]);
    in_valid = 1'b0;
    repeat (16) @(negedge ck);
`ifdef UCODE_LOADER_TIMEOUT_EN
    exp_q.delete();
    exp_done = 1'b0; exp_err = 1'b1;
    check_end("t6");
`else
    check("t6_err_stalled", {31'd0, err}, 32'd0);
    for (int i = 2; i < byte_q.size(); i++) send_byte(byte_q[i]);
    in_valid = 1'b0;
    check_end("t6");
`endif

    // Randomized frames, with occasional junk between frames.
    for (int f = 0; f < 24; f++) begin
      int n, mode;
      if ($urandom_range(0, 2) == 0) begin
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
        in_valid = 1'b0;
      end
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(7, 40) : $urandom_range(1, 6);
      mode = $urandom_range(0, 3);
      build_frame(n, mode);
      send_frame(1'b1);
      check_end($sformatf("rnd%0d", f));
    end

    repeat (2) @(negedge ck);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
